alu_srcb_stage: RTL
===================

Name: alu_srcb_stage

Overview:
- Registered, parametrised successor to the multicycle CPU's ALU operand-B source mux.
- Selects one of NSRC register-file/bus sources, a constant (PC increment), or an extended immediate.
- Pushes each result into a 2-entry output buffer with valid/ready handshakes on both sides.
- Sits between decode/register read and the ALU. Flags illegal selects and keeps a saturating count of them.

Parameters:
- W, 32, operand data width
- NSRC, 2, number of bus sources packed in src_bus
- IMMW, 16, immediate width; must satisfy W >= IMMW+2
- SELW, 3, width of src_sel; must satisfy 2^SELW >= NSRC+2
- CONST_VAL, 4, value driven when src_sel == NSRC
- ECNTW, 8, width of the illegal-select counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request carries a valid selection
- in_ready  out  1  stage can accept a request this cycle
- src_sel  in  SELW  source select
- ext_mode  in  2  immediate extension mode
- src_bus  in  NSRC*W  flattened sources; source k occupies bits [k*W +: W]
- imm  in  IMMW  raw immediate
- out_valid  out  1  buffer head is valid
- out_ready  in  1  consumer takes the head this cycle
- out_data  out  W  head operand
- out_err  out  1  head was produced from an illegal select
- err_count  out  ECNTW  saturating count of accepted illegal selects

Behaviour:
- Reset (asynchronous, rst_n low):
  - buffer count=0, out_valid=0, out_data=0, out_err=0, err_count=0, in_ready=1.
  - Reset mid-transfer discards all buffered entries.
- Selection (combinational, on accept):
  - src_sel < NSRC → src_bus slice src_sel.
  - src_sel == NSRC → CONST_VAL (zero-extended to W).
  - src_sel == NSRC+1 → extended immediate.
  - src_sel > NSRC+1 → data 0, err=1.
- ext_mode:
  - 0 sign-extend imm to W.
  - 1 zero-extend.
  - 2 sign-extend, then shift left by 2 (branch offset).
  - 3 imm placed in bits [W-1 : W-IMMW], lower bits 0 (LUI).
- Accept = in_valid & in_ready.
- Pop = out_valid & out_ready.
- Buffer: 2-entry FIFO of {data, err}; head drives out_data/out_err.
- Latency: an accepted request appears at out_valid on the next rising edge when the buffer was empty.
- in_ready = (count < 2). It is derived only from registers, with no combinational path from out_ready.
- Count transitions:
  - count 0: accept → 1.
  - count 1: accept only → 2; pop only → 0; accept+pop → 1, new entry becomes head next cycle.
  - count 2: in_ready=0; pop → 1, second entry becomes head.
- out_data and out_err hold stable while out_valid=1 and out_ready=0.
- When count=0, out_data/out_err hold their last value; consumers must ignore them.
- err_count increments on each accepted illegal select and saturates at 2^ECNTW-1. It is not cleared except by reset.
- Inputs presented while in_ready=0 are ignored; no state changes.

Decomposition:
- Shared package/include file: ext_mode encodings (EXT_SIGN=0, EXT_ZERO=1, EXT_SHL2=2, EXT_LUI=3) and default CONST_VAL.
- One sub-module, srcb_ext (combinational immediate extender, parameters W/IMMW).
- FIFO and counter stay inline.

Test Plan:
- Default params, src_bus={32'hDEADBEEF, 32'h00000011}, src_sel=0 then 1, out_ready=1 → out_data 32'h00000011 then 32'hDEADBEEF, each one cycle after accept, out_err=0.
- src_sel=2 → out_data=32'h00000004. src_sel=3, imm=16'h8001:
  - ext_mode 0 → 32'hFFFF8001
  - ext_mode 1 → 32'h00008001
  - ext_mode 2 → 32'hFFFE0004
  - ext_mode 3 → 32'h80010000
- src_sel=5 accepted → out_data=0, out_err=1, err_count=1. Repeat 300 illegal accepts with ECNTW=8 → err_count sticks at 255.
- Backpressure: out_ready=0, three back-to-back requests (sel 0,1,2):
  - in_ready drops after the second accept; the third is held off.
  - Raising out_ready drains 0x11, 0xDEADBEEF, then the third is accepted and drained 0x4.
  - Order is preserved.
- Simultaneous push/pop at count=1 for 10 cycles → count stays 1, in_ready=1 throughout, outputs stream in order.
- Assert rst_n low asynchronously with count=2 → out_valid=0, err_count=0, in_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_srcb_stage_pkg.sv
// alu_srcb_stage_pkg: immediate extension encodings and defaults for the ALU operand-B stage
package alu_srcb_stage_pkg;
  typedef enum logic [1:0] {
    EXT_SIGN = 2'd0,
    EXT_ZERO = 2'd1,
    EXT_SHL2 = 2'd2,
    EXT_LUI  = 2'd3
  } ext_mode_e;
  localparam int CONST_VAL_DEF = 4;
endpackage

// File: rtl/alu_srcb_stage_ext.sv
// srcb_ext: combinational immediate extender (sign, zero, branch offset, upper)
module srcb_ext
  import alu_srcb_stage_pkg::*;
#(
  parameter int W    = 32,
  parameter int IMMW = 16
) (
  input  logic [IMMW-1:0] imm,
  input  logic [1:0]      ext_mode,
  output logic [W-1:0]    ext
);
  logic [W-1:0] sx, zx;
  assign sx = {{(W-IMMW){imm[IMMW-1]}}, imm};
  assign zx = {{(W-IMMW){1'b0}}, imm};
  always_comb begin
    ext = ext_mode == EXT_SIGN ? sx :
          ext_mode == EXT_ZERO ? zx :
          ext_mode == EXT_SHL2 ? sx << 2 :
          {imm, {(W-IMMW){1'b0}}};
  end
endmodule

// File: rtl/alu_srcb_stage.sv
// alu_srcb_stage: registered operand-B source select feeding a 2-entry valid/ready buffer
module alu_srcb_stage
  import alu_srcb_stage_pkg::*;
#(
  parameter int W         = 32,
  parameter int NSRC      = 2,
  parameter int IMMW      = 16,
  parameter int SELW      = 3,
  parameter int CONST_VAL = CONST_VAL_DEF,
  parameter int ECNTW     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SELW-1:0]   src_sel,
  input  logic [1:0]        ext_mode,
  input  logic [NSRC*W-1:0] src_bus,
  input  logic [IMMW-1:0]   imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic              out_err,
  output logic [ECNTW-1:0]  err_count
);
  logic [W-1:0] ext, sel_data, d0, d1;
  logic         sel_err, e0, e1, acc, pop;
  logic [1:0]   count;
  srcb_ext #(.W(W), .IMMW(IMMW)) u_ext (.imm(imm), .ext_mode(ext_mode), .ext(ext));
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b0;
    for (int k = 0; k < NSRC; k++)
      if (src_sel == SELW'(k)) sel_data = src_bus[k*W +: W];
    if (src_sel == SELW'(NSRC)) sel_data = W'(CONST_VAL);
    if (src_sel == SELW'(NSRC+1)) sel_data = ext;
    if (src_sel > SELW'(NSRC+1)) sel_err = 1'b1;
  end
  assign in_ready  = ~count[1];
  assign out_valid = count != 2'd0;
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = d0;
  assign out_err   = e0;
  // d0/e0 is the head; d1/e1 only fills when an accept lands on a one-deep buffer that is not popping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      d0        <= '0;
      e0        <= 1'b0;
      d1        <= '0;
      e1        <= 1'b0;
      err_count <= '0;
    end else begin
      count <= count + 2'(acc) - 2'(pop);
      if (acc & sel_err & ~&err_count) err_count <= err_count + 1'b1;
      if (acc && (count == 2'd0 || (count == 2'd1 && pop))) {d0, e0} <= {sel_data, sel_err};
      else if (pop && count == 2'd2) {d0, e0} <= {d1, e1};
      if (acc && count == 2'd1 && !pop) {d1, e1} <= {sel_data, sel_err};
    end
  end
endmodule
